l1_memory_port_arbiter: RTL and testbench

L1_MEMORY_PORT_ARBITER -- requirements
Module: l1_memory_port_arbiter

---
 rtl/l1_memory_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_l1_memory_port_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_memory_port_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single L1 memory port.
// One burst owns the memory at a time; beats and responses pass through unbuffered.
module l1_memory_port_arbiter #(
    parameter int unsigned P_FIRST_PRIORITY = 0
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    // port 0: instruction side
    input  logic        iP0_REQ,
    output logic        oP0_LOCK,
    input  logic [2:0]  iP0_LEN,
    input  logic [1:0]  iP0_ORDER,
    input  logic [3:0]  iP0_MASK,
    input  logic        iP0_RW,
    input  logic [31:0] iP0_ADDR,
    input  logic [31:0] iP0_DATA,
    output logic        oP0_VALID,
    // port 1: data side
    input  logic        iP1_REQ,
    output logic        oP1_LOCK,
    input  logic [2:0]  iP1_LEN,
    input  logic [1:0]  iP1_ORDER,
    input  logic [3:0]  iP1_MASK,
    input  logic        iP1_RW,
    input  logic [31:0] iP1_ADDR,
    input  logic [31:0] iP1_DATA,
    output logic        oP1_VALID,
    output logic [63:0] oP_DATA,
    // memory side
    output logic        oMEM_REQ,
    output logic [1:0]  oMEM_ORDER,
    output logic [3:0]  oMEM_MASK,
    output logic        oMEM_RW,
    output logic [31:0] oMEM_ADDR,
    output logic [31:0] oMEM_DATA,
    input  logic        iMEM_LOCK,
    input  logic        iMEM_VALID,
    input  logic [63:0] iMEM_DATA,
    output logic        oERR_STRAY
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    localparam logic LAST_RESET = (P_FIRST_PRIORITY == 0) ? 1'b1 : 1'b0;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [2:0]  len_q, len_d;
    logic [3:0]  iss_cnt_q, iss_cnt_d;
    logic [3:0]  rsp_cnt_q, rsp_cnt_d;
    logic        err_q, err_d;

    logic        grant;
    logic        own_req;
    logic        beat_acc;
    logic [3:0]  total;

    // On a tie the port that did not win last time gets the grant.
    assign grant    = (iP0_REQ && iP1_REQ) ? ~last_q : iP1_REQ;
    assign own_req  = owner_q ? iP1_REQ : iP0_REQ;
    assign beat_acc = (state_q == S_ISSUE) && own_req && !iMEM_LOCK;
    assign total    = {1'b0, len_q} + 4'd1;

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            last_q    <= LAST_RESET;
            len_q     <= 3'd0;
            iss_cnt_q <= 4'd0;
            rsp_cnt_q <= 4'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            len_q     <= len_d;
            iss_cnt_q <= iss_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        len_d     = len_q;
        iss_cnt_d = iss_cnt_q;
        rsp_cnt_d = rsp_cnt_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (iMEM_VALID) err_d = 1'b1;
                if (iP0_REQ || iP1_REQ) begin
                    state_d   = S_ISSUE;
                    owner_d   = grant;
                    last_d    = grant;
                    len_d     = grant ? iP1_LEN : iP0_LEN;
                    iss_cnt_d = 4'd0;
                    rsp_cnt_d = 4'd0;
                end
            end
            S_ISSUE: begin
                if (beat_acc)   iss_cnt_d = iss_cnt_q + 4'd1;
                if (iMEM_VALID) rsp_cnt_d = rsp_cnt_q + 4'd1;
                // Last response may land with the last beat: skip DRAIN then.
                if (beat_acc && (iss_cnt_d == total))
                    state_d = (rsp_cnt_d == total) ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: begin
                if (iMEM_VALID) rsp_cnt_d = rsp_cnt_q + 4'd1;
                if (rsp_cnt_d == total) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        oP0_LOCK  = 1'b1;
        oP1_LOCK  = 1'b1;
        oP0_VALID = 1'b0;
        oP1_VALID = 1'b0;
        oMEM_REQ  = 1'b0;
        if (state_q == S_ISSUE) begin
            oMEM_REQ = own_req;
            if (owner_q) oP1_LOCK = iMEM_LOCK;
            else         oP0_LOCK = iMEM_LOCK;
        end
        if ((state_q != S_IDLE) && iMEM_VALID) begin
            if (owner_q) oP1_VALID = 1'b1;
            else         oP0_VALID = 1'b1;
        end
    end

    assign oMEM_ORDER = owner_q ? iP1_ORDER : iP0_ORDER;
    assign oMEM_MASK  = owner_q ? iP1_MASK  : iP0_MASK;
    assign oMEM_RW    = owner_q ? iP1_RW    : iP0_RW;
    assign oMEM_ADDR  = owner_q ? iP1_ADDR  : iP0_ADDR;
    assign oMEM_DATA  = owner_q ? iP1_DATA  : iP0_DATA;
    assign oP_DATA    = iMEM_DATA;
    assign oERR_STRAY = err_q;

endmodule

// File: tb/tb_l1_memory_port_arbiter.sv
// Directed bench for l1_memory_port_arbiter; a response scoreboard predicts
// which port each memory response must be routed to.
module tb_l1_memory_port_arbiter;

    logic        iCLOCK = 1'b0;
    logic        iRESET_SYNC;
    logic        iP0_REQ, iP1_REQ;
    logic        oP0_LOCK, oP1_LOCK;
    logic [2:0]  iP0_LEN, iP1_LEN;
    logic [1:0]  iP0_ORDER, iP1_ORDER;
    logic [3:0]  iP0_MASK, iP1_MASK;
    logic        iP0_RW, iP1_RW;
    logic [31:0] iP0_ADDR, iP1_ADDR;
    logic [31:0] iP0_DATA, iP1_DATA;
    logic        oP0_VALID, oP1_VALID;
    logic [63:0] oP_DATA;
    logic        oMEM_REQ;
    logic [1:0]  oMEM_ORDER;
    logic [3:0]  oMEM_MASK;
    logic        oMEM_RW;
    logic [31:0] oMEM_ADDR, oMEM_DATA;
    logic        iMEM_LOCK, iMEM_VALID;
    logic [63:0] iMEM_DATA;
    logic        oERR_STRAY;

    l1_memory_port_arbiter #(.P_FIRST_PRIORITY(0)) dut (
        .iCLOCK(iCLOCK), .iRESET_SYNC(iRESET_SYNC),
        .iP0_REQ(iP0_REQ), .oP0_LOCK(oP0_LOCK), .iP0_LEN(iP0_LEN),
        .iP0_ORDER(iP0_ORDER), .iP0_MASK(iP0_MASK), .iP0_RW(iP0_RW),
        .iP0_ADDR(iP0_ADDR), .iP0_DATA(iP0_DATA), .oP0_VALID(oP0_VALID),
        .iP1_REQ(iP1_REQ), .oP1_LOCK(oP1_LOCK), .iP1_LEN(iP1_LEN),
        .iP1_ORDER(iP1_ORDER), .iP1_MASK(iP1_MASK), .iP1_RW(iP1_RW),
        .iP1_ADDR(iP1_ADDR), .iP1_DATA(iP1_DATA), .oP1_VALID(oP1_VALID),
        .oP_DATA(oP_DATA),
        .oMEM_REQ(oMEM_REQ), .oMEM_ORDER(oMEM_ORDER), .oMEM_MASK(oMEM_MASK),
        .oMEM_RW(oMEM_RW), .oMEM_ADDR(oMEM_ADDR), .oMEM_DATA(oMEM_DATA),
        .iMEM_LOCK(iMEM_LOCK), .iMEM_VALID(iMEM_VALID), .iMEM_DATA(iMEM_DATA),
        .oERR_STRAY(oERR_STRAY)
    );

    always #5 iCLOCK = ~iCLOCK;

    // port = -1 marks a response that has no owner and must be dropped
    typedef struct {
        int          due;
        int          port;
        logic [63:0] data;
    } rsp_t;

    rsp_t        q[$];
    rsp_t        cur;
    rsp_t        ent;
    bit          has_rsp;
    int          cyc;
    int          errors;
    int          checks;
    logic [31:0] addr_exp;
    localparam logic [31:0] BASE = 32'h0000_4000;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        #1;
        cyc++;
        iMEM_VALID = 1'b0;
        has_rsp    = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push_rsp(input int due, input int port, input logic [63:0] data);
        ent.due  = due;
        ent.port = port;
        ent.data = data;
        q.push_back(ent);
    endtask

    task automatic mem_drive();
        has_rsp = 1'b0;
        if (q.size() > 0) begin
            if (q[0].due == cyc) begin
                cur        = q.pop_front();
                has_rsp    = 1'b1;
                iMEM_VALID = 1'b1;
                iMEM_DATA  = cur.data;
            end
        end
    endtask

    task automatic rsp_check();
        if (has_rsp) begin
            chk("p0_valid", {63'd0, oP0_VALID}, {63'd0, cur.port == 0});
            chk("p1_valid", {63'd0, oP1_VALID}, {63'd0, cur.port == 1});
            chk("p_data", oP_DATA, cur.data);
        end else begin
            chk("p0_valid_idle", {63'd0, oP0_VALID}, 64'd0);
            chk("p1_valid_idle", {63'd0, oP1_VALID}, 64'd0);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_p0_lock"}, {63'd0, oP0_LOCK}, 64'd1);
        chk({tag, "_p1_lock"}, {63'd0, oP1_LOCK}, 64'd1);
        chk({tag, "_mem_req"}, {63'd0, oMEM_REQ}, 64'd0);
    endtask

    task automatic do_reset();
        q.delete();
        iRESET_SYNC = 1'b1;
        tick();
        tick();
        iRESET_SYNC = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; has_rsp = 1'b0;
        iRESET_SYNC = 1'b1;
        iP0_REQ = 0; iP1_REQ = 0; iP0_LEN = 0; iP1_LEN = 0;
        iP0_ORDER = 0; iP1_ORDER = 0; iP0_MASK = 0; iP1_MASK = 0;
        iP0_RW = 0; iP1_RW = 0; iP0_ADDR = 0; iP1_ADDR = 0;
        iP0_DATA = 0; iP1_DATA = 0;
        iMEM_LOCK = 0; iMEM_VALID = 0; iMEM_DATA = 0;

        // reset state
        do_reset();
        settle();
        chk_idle("reset");
        chk("reset_err", {63'd0, oERR_STRAY}, 64'd0);
        rsp_check();
        tick();

        // P1 alone, 8-beat read burst, responses two cycles behind the beats
        do_reset();
        iP1_LEN = 3'd7; iP1_RW = 1'b1; iP1_ORDER = 2'd2; iP1_MASK = 4'hF; iP1_DATA = 32'h0;
        for (int k = 0, b = 0; k <= 11; k++) begin
            iP1_REQ  = (k <= 10);
            iP1_ADDR = BASE + 32'(b * 8);
            mem_drive();
            settle();
            if (k == 0 || k == 11) begin
                chk_idle("burst_idle");
            end else if (k <= 8) begin
                addr_exp = BASE + 32'(b * 8);
                chk("burst_req", {63'd0, oMEM_REQ}, 64'd1);
                chk("burst_addr", {32'd0, oMEM_ADDR}, {32'd0, addr_exp});
                chk("burst_rw", {63'd0, oMEM_RW}, 64'd1);
                chk("burst_p1_lock", {63'd0, oP1_LOCK}, 64'd0);
                chk("burst_p0_lock", {63'd0, oP0_LOCK}, 64'd1);
                push_rsp(cyc + 2, 1, {32'hA5A5_0000 | 32'(b), addr_exp});
                b++;
            end else begin
                chk("drain_req", {63'd0, oMEM_REQ}, 64'd0);
                chk("drain_p1_lock", {63'd0, oP1_LOCK}, 64'd1);
            end
            rsp_check();
            tick();
        end
        chk("burst_sb_empty", 64'(q.size()), 64'd0);

        // both ports request continuously: grants alternate starting with P0
        do_reset();
        iP0_REQ = 1; iP1_REQ = 1; iP0_LEN = 0; iP1_LEN = 0;
        iP0_RW = 1; iP1_RW = 1;
        iP0_ADDR = 32'h1000; iP1_ADDR = 32'h2000;
        for (int t = 0; t < 4; t++) begin
            mem_drive(); settle();
            chk_idle("alt_idle");
            rsp_check(); tick();
            mem_drive(); settle();
            addr_exp = (t % 2 == 1) ? 32'h2000 : 32'h1000;
            chk("alt_addr", {32'd0, oMEM_ADDR}, {32'd0, addr_exp});
            chk("alt_p0_lock", {63'd0, oP0_LOCK}, {63'd0, t % 2 == 1});
            chk("alt_p1_lock", {63'd0, oP1_LOCK}, {63'd0, t % 2 == 0});
            push_rsp(cyc + 1, t % 2, {32'hBEEF_0000 | 32'(t), addr_exp});
            rsp_check(); tick();
            mem_drive(); settle();
            chk("alt_drain_req", {63'd0, oMEM_REQ}, 64'd0);
            chk("alt_drain_p0_lock", {63'd0, oP0_LOCK}, 64'd1);
            chk("alt_drain_p1_lock", {63'd0, oP1_LOCK}, 64'd1);
            rsp_check(); tick();
        end
        iP0_REQ = 0; iP1_REQ = 0;

        // P0 single write stalled 3 cycles, response with last beat, then stray
        do_reset();
        iP0_REQ = 1; iP0_LEN = 0; iP0_RW = 0; iP0_DATA = 32'hCAFE_BABE;
        iP0_ADDR = 32'h3000; iP0_MASK = 4'h3; iP0_ORDER = 2'd1; iMEM_LOCK = 1;
        settle(); chk_idle("wr_idle"); tick();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("wr_stall_lock", {63'd0, oP0_LOCK}, 64'd1);
            chk("wr_req", {63'd0, oMEM_REQ}, 64'd1);
            chk("wr_rw", {63'd0, oMEM_RW}, 64'd0);
            chk("wr_data", {32'd0, oMEM_DATA}, 64'hCAFE_BABE);
            chk("wr_mask", {60'd0, oMEM_MASK}, 64'h3);
            tick();
        end
        iMEM_LOCK = 0;
        push_rsp(cyc, 0, 64'h0123_4567_89AB_CDEF);
        mem_drive(); settle();
        chk("wr_accept_lock", {63'd0, oP0_LOCK}, 64'd0);
        rsp_check(); tick();
        iP0_REQ = 0;
        push_rsp(cyc, -1, 64'hDEAD_DEAD_DEAD_DEAD);
        mem_drive(); settle();
        chk_idle("wr_after");
        chk("stray_err_before", {63'd0, oERR_STRAY}, 64'd0);
        rsp_check(); tick();
        settle(); chk("stray_err_set", {63'd0, oERR_STRAY}, 64'd1); tick();
        settle(); chk("stray_err_sticky", {63'd0, oERR_STRAY}, 64'd1); tick();

        // reset after 3 of 8 beats; the remaining in-flight response is stray
        do_reset();
        iP0_REQ = 1; iP0_LEN = 3'd7; iP0_RW = 1; iP0_ADDR = BASE;
        settle(); chk_idle("abort_idle");
        chk("abort_err_cleared", {63'd0, oERR_STRAY}, 64'd0);
        tick();
        for (int k = 1; k <= 3; k++) begin
            iP0_ADDR = BASE + 32'((k - 1) * 8);
            mem_drive(); settle();
            chk("abort_req", {63'd0, oMEM_REQ}, 64'd1);
            push_rsp(cyc + 2, 0, {32'h7777_0000 | 32'(k), iP0_ADDR});
            rsp_check(); tick();
        end
        iRESET_SYNC = 1'b1;
        mem_drive();
        tick();
        iRESET_SYNC = 1'b0;
        iP0_REQ = 0;
        foreach (q[i]) q[i].port = -1;
        mem_drive(); settle();
        chk_idle("abort_after");
        chk("abort_err_pre", {63'd0, oERR_STRAY}, 64'd0);
        rsp_check(); tick();
        settle(); chk("abort_err_set", {63'd0, oERR_STRAY}, 64'd1);
        chk("abort_sb_empty", 64'(q.size()), 64'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
